risc_control_unit: RTL and testbench

//   Multi-cycle FSM sequencer for the 8-bit RISC datapath (Processing_Unit).

---
 rtl/risc_pkg.sv | 40 ++++
 rtl/risc_control_unit_if.sv | 38 +++
 rtl/risc_cu_load_decode.sv | 15 +
 rtl/risc_control_unit.sv | 168 ++++++++++++++++
 tb/tb_risc_control_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC control unit and datapath:
// opcodes, FSM state encoding and bus-mux select codes.
package risc_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StFet1 = 4'd1,
    StFet2 = 4'd2,
    StDec  = 4'd3,
    StEx1  = 4'd4,
    StRd1  = 4'd5,
    StRd2  = 4'd6,
    StWr1  = 4'd7,
    StWr2  = 4'd8,
    StBr1  = 4'd9,
    StBr2  = 4'd10,
    StHalt = 4'd11
  } state_e;

endpackage

// File: rtl/risc_control_unit_if.sv
// Control bundle between the RISC control unit (master) and the datapath (slave).
interface risc_control_unit_if #(
  parameter int unsigned word_size = 8,
  parameter int unsigned Sel1_size = 3,
  parameter int unsigned Sel2_size = 2
);

  logic [word_size-1:0] instruction;
  logic                 Zflag;
  logic                 Load_R0;
  logic                 Load_R1;
  logic                 Load_R2;
  logic                 Load_R3;
  logic                 Load_PC;
  logic                 Inc_PC;
  logic [Sel1_size-1:0] Sel_Bus_1_Mux;
  logic [Sel2_size-1:0] Sel_Bus_2_Mux;
  logic                 Load_IR;
  logic                 Load_Add_R;
  logic                 Load_Reg_Y;
  logic                 Load_Reg_Z;
  logic                 write;

  modport master (
    input  instruction, Zflag,
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
    output Sel_Bus_1_Mux, Sel_Bus_2_Mux,
    output Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write
  );

  modport slave (
    output instruction, Zflag,
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
    input  Sel_Bus_1_Mux, Sel_Bus_2_Mux,
    input  Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write
  );

endinterface

// File: rtl/risc_cu_load_decode.sv
// Register-file load decoder: {en, idx} -> at most one of Load_R0..R3.
module risc_cu_load_decode (
  input  logic       en,
  input  logic [1:0] idx,
  output logic [3:0] load_r
);

  always_comb begin
    load_r = '0;
    if (en) begin
      load_r[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/risc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC datapath.
// Define RISC_CU_HALT_ON_ILLEGAL_EN to halt on opcodes 9..15; otherwise they act as NOP.
module risc_control_unit
  import risc_pkg::*;
#(
  parameter int unsigned word_size = 8,
  parameter int unsigned op_size   = 4,
  parameter int unsigned Sel1_size = 3,
  parameter int unsigned Sel2_size = 2
) (
  input  logic                clk,
  input  logic                rst,
  risc_control_unit_if.master bus
);

  state_e state_q, state_d;

  logic [op_size-1:0]   opcode;
  logic [1:0]           src;
  logic [1:0]           dest;
  logic [Sel1_size-1:0] sel1;
  logic [Sel2_size-1:0] sel2;
  logic                 load_r_en;
  logic [3:0]           load_r;
  logic                 load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write_en;

  assign opcode = bus.instruction[word_size-1 -: op_size];
  assign src    = bus.instruction[3:2];
  assign dest   = bus.instruction[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel1       = '0;
    sel2       = '0;
    load_r_en  = 1'b0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write_en   = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFet1;
      StFet1: begin
        sel1       = Sel1_size'(SEL1_PC);
        sel2       = Sel2_size'(SEL2_BUS1);
        load_add_r = 1'b1;
        state_d    = StFet2;
      end
      StFet2: begin
        sel2    = Sel2_size'(SEL2_MEM);
        load_ir = 1'b1;
        inc_pc  = 1'b1;
        state_d = StDec;
      end
      StDec: begin
        state_d = StFet1;
        case (opcode)
          OP_NOP: state_d = StFet1;
          OP_ADD, OP_SUB, OP_AND: begin
            sel1       = Sel1_size'(src);
            sel2       = Sel2_size'(SEL2_BUS1);
            load_reg_y = 1'b1;
            state_d    = StEx1;
          end
          OP_NOT: begin
            sel1       = Sel1_size'(src);
            sel2       = Sel2_size'(SEL2_ALU);
            load_r_en  = 1'b1;
            load_reg_z = 1'b1;
            state_d    = StFet1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel1       = Sel1_size'(SEL1_PC);
            sel2       = Sel2_size'(SEL2_BUS1);
            load_add_r = 1'b1;
            state_d    = (opcode == OP_RD) ? StRd1 : (opcode == OP_WR) ? StWr1 : StBr1;
          end
          OP_BRZ: begin
            if (bus.Zflag) begin
              sel1       = Sel1_size'(SEL1_PC);
              sel2       = Sel2_size'(SEL2_BUS1);
              load_add_r = 1'b1;
              state_d    = StBr1;
            end else begin
              // Not taken: step PC over the operand byte.
              inc_pc  = 1'b1;
              state_d = StFet1;
            end
          end
          default: begin
`ifdef RISC_CU_HALT_ON_ILLEGAL_EN
            state_d = StHalt;
`else
            state_d = StFet1;
`endif
          end
        endcase
      end
      StEx1: begin
        sel1       = Sel1_size'(dest);
        sel2       = Sel2_size'(SEL2_ALU);
        load_r_en  = 1'b1;
        load_reg_z = 1'b1;
        state_d    = StFet1;
      end
      StRd1, StWr1: begin
        sel2       = Sel2_size'(SEL2_MEM);
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_d    = (state_q == StRd1) ? StRd2 : StWr2;
      end
      StRd2: begin
        sel2      = Sel2_size'(SEL2_MEM);
        load_r_en = 1'b1;
        state_d   = StFet1;
      end
      StWr2: begin
        sel1     = Sel1_size'(src);
        write_en = 1'b1;
        state_d  = StFet1;
      end
      StBr1: begin
        sel2       = Sel2_size'(SEL2_MEM);
        load_add_r = 1'b1;
        state_d    = StBr2;
      end
      StBr2: begin
        sel2    = Sel2_size'(SEL2_MEM);
        load_pc = 1'b1;
        state_d = StFet1;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  risc_cu_load_decode u_load_decode (
    .en     (load_r_en),
    .idx    (dest),
    .load_r (load_r)
  );

  assign bus.Load_R0       = load_r[0];
  assign bus.Load_R1       = load_r[1];
  assign bus.Load_R2       = load_r[2];
  assign bus.Load_R3       = load_r[3];
  assign bus.Load_PC       = load_pc;
  assign bus.Inc_PC        = inc_pc;
  assign bus.Sel_Bus_1_Mux = sel1;
  assign bus.Sel_Bus_2_Mux = sel2;
  assign bus.Load_IR       = load_ir;
  assign bus.Load_Add_R    = load_add_r;
  assign bus.Load_Reg_Y    = load_reg_y;
  assign bus.Load_Reg_Z    = load_reg_z;
  assign bus.write         = write_en;

endmodule

// File: tb/tb_risc_control_unit.sv
// Self-checking bench for risc_control_unit: directed scenarios plus random
// instruction streams checked against a per-instruction micro-step model.
module tb_risc_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc_control_unit_if bus ();

  risc_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // {Load_R3..R0, Load_PC, Inc_PC, Sel1[2:0], Sel2[1:0], Load_IR, Load_Add_R, Y, Z, write}
  typedef logic [15:0] vec_t;

  vec_t exp_q[$];
  vec_t obs_q[$];

  function automatic vec_t obs();
    return {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0, bus.Load_PC, bus.Inc_PC,
            bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux, bus.Load_IR, bus.Load_Add_R,
            bus.Load_Reg_Y, bus.Load_Reg_Z, bus.write};
  endfunction

  function automatic vec_t mk(int s1, int s2, bit add_r, bit ir, bit inc, bit pc,
                              bit y, bit z, bit wr, int ld);
    logic [3:0] l;
    l = 4'b0000;
    if (ld >= 0) l[ld] = 1'b1;
    return {l, pc, inc, 3'(s1), 2'(s2), ir, add_r, y, z, wr};
  endfunction

  function automatic vec_t fet1_v();
    return mk(4, 1, 1, 0, 0, 0, 0, 0, 0, -1);
  endfunction

  // Expected output per cycle from fet2 through the next fet1, per instruction.
  function automatic void model(logic [7:0] ins, bit zf);
    int op, src, dst;
    op  = int'(ins[7:4]);
    src = int'(ins[3:2]);
    dst = int'(ins[1:0]);
    exp_q.delete();
    exp_q.push_back(mk(0, 2, 0, 1, 1, 0, 0, 0, 0, -1));
    if (op >= 1 && op <= 3) begin
      exp_q.push_back(mk(src, 1, 0, 0, 0, 0, 1, 0, 0, -1));
      exp_q.push_back(mk(dst, 0, 0, 0, 0, 0, 0, 1, 0, dst));
    end else if (op == 4) begin
      exp_q.push_back(mk(src, 0, 0, 0, 0, 0, 0, 1, 0, dst));
    end else if (op == 5 || op == 6 || op == 7 || (op == 8 && zf)) begin
      exp_q.push_back(fet1_v());
      if (op == 5) begin
        exp_q.push_back(mk(0, 2, 1, 0, 1, 0, 0, 0, 0, -1));
        exp_q.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, dst));
      end else if (op == 6) begin
        exp_q.push_back(mk(0, 2, 1, 0, 1, 0, 0, 0, 0, -1));
        exp_q.push_back(mk(src, 0, 0, 0, 0, 0, 0, 0, 1, -1));
      end else begin
        exp_q.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, -1));
        exp_q.push_back(mk(0, 2, 0, 0, 0, 1, 0, 0, 0, -1));
      end
    end else if (op == 8) begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, -1));
    end else begin
      exp_q.push_back(16'h0000);
    end
    exp_q.push_back(fet1_v());
  endfunction

  // Called just after fet1 is sampled; records n cycles starting at fet2.
  task automatic capture(input logic [7:0] ins, input bit zf, input int n);
    bus.instruction = ins;
    bus.Zflag       = zf;
    obs_q.delete();
    repeat (n) begin
      @(negedge clk);
      obs_q.push_back(obs());
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.instruction = 8'h00;
    bus.Zflag       = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 16'h0000) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: got %h expected 0000", i, obs());
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== fet1_v()) begin
      failures++;
      $display("FAIL reset_fet1: got %h expected %h", obs(), fet1_v());
    end
  endtask

  task automatic test_add();
    model(8'h16, 1'b0);
    capture(8'h16, 1'b0, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL add cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[2][15:12] !== 4'b0100) begin
      failures++;
      $display("FAIL add_load_r2: got %b expected 0100", obs_q[2][15:12]);
    end
  endtask

  task automatic test_rd();
    model(8'h5C, 1'b0);
    capture(8'h5C, 1'b0, 5);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rd cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wr();
    int n_write;
    model(8'h68, 1'b0);
    capture(8'h68, 1'b0, 5);
    n_write = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i][0]) begin
        n_write++;
        checks++;
        if (obs_q[i][9:7] !== 3'd2 || obs_q[i][15:11] !== 5'b0 || obs_q[i][4:1] !== 4'b0) begin
          failures++;
          $display("FAIL wr_strobe_cycle: got %h expected sel1=2 and no loads", obs_q[i]);
        end
      end
    end
    checks++;
    if (n_write !== 1) begin
      failures++;
      $display("FAIL wr_strobe_count: got %0d expected 1", n_write);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wr cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_brz();
    for (int zf = 0; zf < 2; zf++) begin
      model(8'h80, zf[0]);
      capture(8'h80, zf[0], (zf == 0) ? 3 : 5);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL brz_z%0d cyc%0d: got %h expected %h", zf, i, obs_q[i], exp_q[i]);
        end
        checks++;
        if (obs_q[i][11] && obs_q[i][10]) begin
          failures++;
          $display("FAIL brz_pc_conflict cyc%0d: got %h expected Load_PC and Inc_PC exclusive",
                   i, obs_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    capture(8'h68, 1'b0, 3);
    @(negedge clk);
    checks++;
    if (bus.write !== 1'b1) begin
      failures++;
      $display("FAIL midrst_wr2_write: got %b expected 1", bus.write);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_idle: got %h expected 0000", obs());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== fet1_v()) begin
      failures++;
      $display("FAIL midrst_fet1: got %h expected %h", obs(), fet1_v());
    end
  endtask

  task automatic test_illegal();
`ifdef RISC_CU_HALT_ON_ILLEGAL_EN
    capture(8'hF0, 1'b0, 6);
    checks++;
    if (obs_q[0] !== mk(0, 2, 0, 1, 1, 0, 0, 0, 0, -1)) begin
      failures++;
      $display("FAIL halt_fet2: got %h", obs_q[0]);
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (obs_q[i] !== 16'h0000) begin
        failures++;
        $display("FAIL halt cyc%0d: got %h expected 0000", i, obs_q[i]);
      end
    end
    apply_reset();
`else
    model(8'hF0, 1'b0);
    capture(8'hF0, 1'b0, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL illegal_nop cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] ins;
    bit         zf;
    for (int k = 0; k < 80; k++) begin
      ins = 8'($urandom);
`ifdef RISC_CU_HALT_ON_ILLEGAL_EN
      if (ins[7:4] > 4'd8) ins[7:4] = 4'($urandom_range(0, 8));
`endif
      zf = 1'($urandom_range(0, 1));
      model(ins, zf);
      capture(ins, zf, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random ins=%h z=%0d cyc%0d: got %h expected %h",
                   ins, zf, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rd();
    test_wr();
    test_brz();
    test_reset_mid_write();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
